// File: rtl/uart_rx_framer_if.sv
// UART receive framer port bundle.
// Generator handshake plus CPU-side data/flag register view.
interface uart_rx_framer_if;
    logic       baud_tick;
    logic       baud_status;
    logic       baud_finish;
    logic       baud_trigger;
    logic       baud_enable;
    logic       baud_type;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    modport master (
        input  baud_tick,
        input  baud_status,
        input  baud_finish,
        input  rd_ack,
        output baud_trigger,
        output baud_enable,
        output baud_type,
        output rx_data,
        output rx_ready,
        output rx_valid,
        output frame_err,
        output overrun
    );

    modport slave (
        output baud_tick,
        output baud_status,
        output baud_finish,
        output rd_ack,
        input  baud_trigger,
        input  baud_enable,
        input  baud_type,
        input  rx_data,
        input  rx_ready,
        input  rx_valid,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/uart_rx_framer.sv
// UART receive framer: start detect, bit sampling on generator ticks,
// byte hand-off to the CPU with ready/ack, frame-error and overrun flags.
module uart_rx_framer #(
    parameter int SYNC_STAGES = 2,
    parameter bit CHECK_STOP  = 1'b1
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             rx,
    uart_rx_framer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        DATA,
        STOP,
        DRAIN,
        DISCARD
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rxs;
    logic                   rxs_dly_q, rxs_dly_d;
    logic                   fall;

    logic       trig_q, trig_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] sr_q, sr_d;
    logic       stop_ok_q, stop_ok_d;
    logic [7:0] data_q, data_d;
    logic       ferr_q, ferr_d;
    logic       ready_q, ready_d;
    logic       valid_q, valid_d;
    logic       ovr_q, ovr_d;

    assign rxs  = sync_q[SYNC_STAGES-1];
    assign fall = rxs_dly_q & ~rxs;

    // Shift the raw line through the synchroniser; keep one older copy for edges.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], rx};
        rxs_dly_d = rxs;
    end

    // Framing FSM, byte hand-off and CPU flag updates.
    always_comb begin
        state_d   = state_q;
        trig_d    = trig_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        stop_ok_d = stop_ok_q;
        data_d    = data_q;
        ferr_d    = ferr_q;
        ready_d   = ready_q;
        valid_d   = 1'b0;
        ovr_d     = ovr_q;

        if (bus.rd_ack && ready_q) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (fall && !bus.baud_status) begin
                    trig_d  = 1'b1;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (bus.baud_status) begin
                    trig_d  = 1'b0;
                    state_d = START;
                end else if (bus.baud_finish) begin
                    trig_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            START: begin
                if (bus.baud_finish) begin
                    state_d = IDLE;
                end else if (bus.baud_tick) begin
                    if (rxs) begin
                        state_d = DISCARD;
                    end else begin
                        state_d = DATA;
                        cnt_d   = 3'd0;
                    end
                end
            end
            DATA: begin
                if (bus.baud_finish) begin
                    state_d = IDLE;
                end else if (bus.baud_tick) begin
                    sr_d  = {rxs, sr_q[7:1]};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (CHECK_STOP) begin
                            state_d = STOP;
                        end else begin
                            state_d   = DRAIN;
                            stop_ok_d = 1'b1;
                        end
                    end
                end
            end
            STOP: begin
                if (bus.baud_finish) begin
                    state_d = IDLE;
                end else if (bus.baud_tick) begin
                    stop_ok_d = rxs;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.baud_finish) begin
                    state_d = IDLE;
                    if (!ready_q || bus.rd_ack) begin
                        data_d  = sr_q;
                        ferr_d  = ~stop_ok_q;
                        ready_d = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (bus.baud_finish) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                trig_d  = 1'b0;
            end
        endcase
    end

    // Synchroniser and edge-detect registers; the line idles high.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '1;
            rxs_dly_q <= 1'b1;
        end else begin
            sync_q    <= sync_d;
            rxs_dly_q <= rxs_dly_d;
        end
    end

    // FSM state and receive datapath registers.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            trig_q    <= 1'b0;
            cnt_q     <= 3'd0;
            sr_q      <= 8'h00;
            stop_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            trig_q    <= trig_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            stop_ok_q <= stop_ok_d;
        end
    end

    // CPU-visible data register and status flags.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= 8'h00;
            ferr_q  <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            ferr_q  <= ferr_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.baud_trigger = trig_q;
    assign bus.baud_enable  = 1'b1;
    assign bus.baud_type    = CHECK_STOP;
    assign bus.rx_data      = data_q;
    assign bus.rx_ready     = ready_q;
    assign bus.rx_valid     = valid_q;
    assign bus.frame_err    = ferr_q;
    assign bus.overrun      = ovr_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: behavioural generator, frame-level model,
// per-cycle compare, directed cases and randomized frames.
module tb_uart_rx_framer;

    localparam int BIT = 16;
    localparam int HB  = BIT / 2;
    localparam int NT  = 10;
    localparam int FIN = HB + (NT - 1) * BIT + BIT / 4;

    typedef struct {
        logic [7:0] b;
        logic       s;
    } fr_t;

    logic sysclk = 1'b0;
    logic rst_n;
    logic rx;

    uart_rx_framer_if bus();

    uart_rx_framer #(
        .SYNC_STAGES(2),
        .CHECK_STOP (1'b1)
    ) dut (
        .sysclk(sysclk),
        .rst_n (rst_n),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 sysclk = ~sysclk;

    int total = 0;
    int bad   = 0;
    int gcnt  = 0;
    int gruns = 0;
    int vcnt  = 0;
    logic fin_prev;
    logic trig_prev = 1'b0;
    logic stat_prev = 1'b0;

    fr_t fq[$];

    logic [7:0] m_data;
    logic       m_ready;
    logic       m_valid;
    logic       m_ferr;
    logic       m_ovr;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural baud generator: mid-bit ticks, finish a quarter bit after the last tick.
    initial begin
        bus.baud_tick   = 1'b0;
        bus.baud_status = 1'b0;
        bus.baud_finish = 1'b0;
        forever begin
            @(posedge sysclk);
            #1;
            bus.baud_tick   = 1'b0;
            bus.baud_finish = 1'b0;
            if (bus.baud_status) begin
                gcnt++;
                if (gcnt >= HB && (gcnt - HB) % BIT == 0 && (gcnt - HB) / BIT < NT)
                    bus.baud_tick = 1'b1;
                if (gcnt == FIN) begin
                    bus.baud_finish = 1'b1;
                    bus.baud_status = 1'b0;
                end
            end else if (bus.baud_trigger) begin
                bus.baud_status = 1'b1;
                gcnt = 0;
                gruns++;
            end
        end
    end

    // Frame-level reference: each real frame is resolved at its generator finish.
    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            m_data  <= 8'h00;
            m_ready <= 1'b0;
            m_valid <= 1'b0;
            m_ferr  <= 1'b0;
            m_ovr   <= 1'b0;
            fq.delete();
        end else begin
            m_valid <= 1'b0;
            if (bus.rd_ack && m_ready) begin
                m_ready <= 1'b0;
                m_ovr   <= 1'b0;
            end
            if (bus.baud_finish && fq.size() != 0) begin
                if (!m_ready || bus.rd_ack) begin
                    m_data  <= fq[0].b;
                    m_ferr  <= !fq[0].s;
                    m_ready <= 1'b1;
                    m_valid <= 1'b1;
                end else begin
                    m_ovr <= 1'b1;
                end
                fq.delete(0);
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge sysclk) begin
        check("rx_data", bus.rx_data, m_data);
        check("rx_ready", bus.rx_ready, m_ready);
        check("rx_valid", bus.rx_valid, m_valid);
        check("frame_err", bus.frame_err, m_ferr);
        check("overrun", bus.overrun, m_ovr);
        check("baud_enable", bus.baud_enable, 1);
        check("baud_type", bus.baud_type, 1);
        if (bus.baud_trigger && !trig_prev)
            check("trigger_while_busy", stat_prev, 0);
        trig_prev <= bus.baud_trigger;
        stat_prev <= bus.baud_status;
        vcnt      <= vcnt + int'(bus.rx_valid);
    end

    // mode: 0 no ack, 1 random ack, 2 ack with finish, 3 ack after finish, 4 ack now
    task automatic step(input logic rxv, input int mode);
        @(posedge sysclk);
        #2;
        rx = rxv;
        case (mode)
            1:       bus.rd_ack = ($urandom_range(0, 29) == 0);
            2:       bus.rd_ack = bus.baud_finish;
            3:       bus.rd_ack = fin_prev;
            4:       bus.rd_ack = 1'b1;
            default: bus.rd_ack = 1'b0;
        endcase
        fin_prev = bus.baud_finish;
    endtask

    task automatic idle(input int n, input int mode);
        repeat (n) step(1'b1, mode);
    endtask

    task automatic ack();
        step(1'b1, 4);
        idle(2, 0);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic s, input int mode);
        fq.push_back('{b, s});
        repeat (BIT) step(1'b0, mode);
        for (int i = 0; i < 8; i++)
            repeat (BIT) step(b[i], mode);
        repeat (BIT) step(s, mode);
    endtask

    task automatic check_reset_vals();
        check("rst_rx_data", bus.rx_data, 8'h00);
        check("rst_rx_ready", bus.rx_ready, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_trigger", bus.baud_trigger, 0);
        check("rst_enable", bus.baud_enable, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int g0;
        int w;
        logic [7:0] rb;
        logic       rs;

        rst_n      = 1'b0;
        rx         = 1'b1;
        bus.rd_ack = 1'b0;
        fin_prev   = 1'b0;
        repeat (4) @(posedge sysclk);
        #2;
        check_reset_vals();
        rst_n = 1'b1;
        idle(20, 0);

        v0 = vcnt;
        send_frame(8'hA5, 1'b1, 0);
        idle(4, 0);
        check("a5_data", bus.rx_data, 8'hA5);
        check("a5_ready", bus.rx_ready, 1);
        check("a5_ferr", bus.frame_err, 0);
        check("a5_ovr", bus.overrun, 0);
        check("a5_valid_pulses", vcnt - v0, 1);
        ack();
        check("a5_ack_ready", bus.rx_ready, 0);

        send_frame(8'h3C, 1'b0, 0);
        idle(4, 0);
        check("3c_data", bus.rx_data, 8'h3C);
        check("3c_ready", bus.rx_ready, 1);
        check("3c_ferr", bus.frame_err, 1);
        ack();
        idle(4, 0);

        v0 = vcnt;
        g0 = gruns;
        repeat (4) step(1'b0, 0);
        idle(FIN + 20, 0);
        check("glitch_gen_runs", gruns - g0, 1);
        check("glitch_gen_idle", bus.baud_status, 0);
        check("glitch_ready", bus.rx_ready, 0);
        check("glitch_valid", vcnt - v0, 0);

        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 0);
        idle(4, 0);
        check("ovr_data", bus.rx_data, 8'h11);
        check("ovr_flag", bus.overrun, 1);
        check("ovr_ready", bus.rx_ready, 1);
        ack();
        check("ovr_ack_ready", bus.rx_ready, 0);
        check("ovr_ack_flag", bus.overrun, 0);

        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h77, 1'b1, 0);
        idle(4, 0);
        check("coin_pre_ovr", bus.overrun, 1);
        send_frame(8'h22, 1'b1, 2);
        idle(4, 0);
        check("coin_data", bus.rx_data, 8'h22);
        check("coin_ready", bus.rx_ready, 1);
        check("coin_ovr", bus.overrun, 0);

        fq.push_back('{8'hFF, 1'b1});
        repeat (BIT) step(1'b0, 0);
        repeat (4 * BIT + BIT / 2) step(1'b1, 0);
        rst_n = 1'b0;
        repeat (3) step(1'b1, 0);
        check_reset_vals();
        rst_n = 1'b1;
        w = 0;
        while (bus.baud_status && w < 2 * FIN) begin
            step(1'b1, 0);
            w++;
        end
        check("rst_gen_done", bus.baud_status, 0);
        idle(5, 0);
        send_frame(8'h5A, 1'b1, 0);
        idle(4, 0);
        check("5a_data", bus.rx_data, 8'h5A);
        check("5a_ferr", bus.frame_err, 0);
        check("5a_ready", bus.rx_ready, 1);
        ack();

        v0 = vcnt;
        send_frame(8'h00, 1'b1, 3);
        send_frame(8'hFF, 1'b1, 3);
        idle(4, 3);
        check("b2b_data", bus.rx_data, 8'hFF);
        check("b2b_ferr", bus.frame_err, 0);
        check("b2b_valid_pulses", vcnt - v0, 2);
        check("b2b_ready", bus.rx_ready, 0);

        rs = 1'b1;
        for (int i = 0; i < 40; i++) begin
            idle($urandom_range(rs ? 0 : 3, 30), 1);
            rb = 8'($urandom);
            rs = ($urandom_range(0, 5) != 0);
            send_frame(rb, rs, 1);
        end
        idle(FIN, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- Serial receive stage directly downstream of the baud/sample-tick generator in the UART peripheral of the single-cycle MIPS CPU.
- Detects a start bit on the synchronised rx line and triggers the generator.
- Samples start, 8 data bits (LSB first) and optionally the stop bit on each one-cycle sample tick.
- Presents the byte to the CPU bus side with a ready/acknowledge handshake, plus frame-error and overrun flags.

Parameters:
- SYNC_STAGES, 2, number of flip-flops synchronising rx to sysclk (minimum 2).
- CHECK_STOP, 1, 1 = drive baud_type=1 (10 ticks) and check the stop bit; 0 = baud_type=0 (9 ticks), no stop check.

Ports:
- sysclk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  raw serial line, idle high.
- baud_tick  in  1  one-sysclk sample pulse from the generator, mid-bit.
- baud_status  in  1  generator busy.
- baud_finish  in  1  one-sysclk pulse at end of generator run.
- baud_trigger  out  1  start request to the generator.
- baud_enable  out  1  generator enable; constant 1 out of reset.
- baud_type  out  1  equals CHECK_STOP.
- rd_ack  in  1  CPU has read the data register; one-cycle pulse.
- rx_data  out  8  last accepted byte.
- rx_ready  out  1  unread byte present.
- rx_valid  out  1  one-cycle pulse when a byte is accepted.
- frame_err  out  1  stop bit of the accepted byte sampled 0.
- overrun  out  1  byte completed while rx_ready=1; sticky.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: rx_data=0x00, rx_ready=0, rx_valid=0, frame_err=0, overrun=0, baud_trigger=0, baud_enable=1.
  - Synchroniser flops=1, FSM=IDLE.
  - Reset mid-frame abandons the frame. The generator keeps running; on exit from reset the FSM must not retrigger until baud_status=0.
- Synchroniser: rx passes through SYNC_STAGES flops to give rxs. A falling edge is rxs_d=1 and rxs=0 (one extra flop).
- FSM states: IDLE, ARM, START, DATA, STOP, DRAIN, DISCARD.
- IDLE:
  - On a falling edge with baud_status=0: baud_trigger<=1, go to ARM.
  - A falling edge while baud_status=1 is ignored.
- ARM:
  - Hold baud_trigger=1 until baud_status=1, then baud_trigger<=0 and go to START.
  - Exactly one extra trigger-high cycle is permitted.
- START, on baud_tick:
  - rxs=0: go to DATA, bit counter=0.
  - rxs=1 (false start/glitch): go to DISCARD.
- DATA, on each baud_tick:
  - shift register <= {rxs, sr[7:1]}; counter+1.
  - After the 8th tick: go to STOP if CHECK_STOP=1, else to DRAIN with stop_ok=1.
- STOP: on baud_tick, stop_ok<=rxs, go to DRAIN.
- DRAIN, on baud_finish: accept the byte, then go to IDLE.
  - If rx_ready=0, or rd_ack=1 in the same cycle: rx_data<=sr, frame_err<=~stop_ok, rx_ready<=1, rx_valid pulses 1 cycle.
  - Otherwise: overrun<=1; the new byte is discarded; rx_data and frame_err are unchanged.
- DISCARD: ignore ticks; on baud_finish go to IDLE. No flag changes.
- Ticks arriving in IDLE or ARM are ignored.
- baud_finish arriving outside DRAIN/DISCARD returns the FSM to IDLE without acceptance (defensive).
- rd_ack: clears rx_ready and overrun next cycle.
  - rd_ack with rx_ready=0 has no effect.
  - rd_ack simultaneous with acceptance: the new byte wins; rx_ready stays 1; overrun is cleared.
- A line held low after the frame produces no new frame until rxs returns high and falls again.
- Latency: rx_valid is asserted the cycle after baud_finish, about half a bit after the stop-bit sample.

Test Plan:
- Real generator attached (bit period 10204 sysclk, CHECK_STOP=1).
  - Send 0xA5 with stop=1 -> after baud_finish: rx_data=0xA5, rx_ready=1, rx_valid 1 cycle, frame_err=0, overrun=0.
  - Send 0x3C with stop=0 -> rx_data=0x3C, rx_ready=1, frame_err=1.
- rx low for 2000 cycles then high -> FSM reaches DISCARD, then IDLE after baud_finish; rx_ready stays 0, rx_valid never pulses.
- Overrun:
  - Send 0x11, then 0x22 without rd_ack -> rx_data=0x11, overrun=1.
  - Then rd_ack -> rx_ready=0, overrun=0.
  - rd_ack coincident with the 0x22 acceptance -> rx_data=0x22, rx_ready=1, overrun=0.
- Reset and retrigger:
  - Assert rst_n=0 during bit 4 of 0xFF -> all outputs at reset values.
  - Next frame 0x5A sent after the generator's baud_finish -> received correctly.
  - No baud_trigger while baud_status=1.
- Back-to-back frames 0x00, 0xFF with one stop bit each, rd_ack after each -> both received, no frame_err.
